l1_cache_ctrl: RTL
==================

// Module: l1_cache_ctrl
// PURPOSE
//  Sequencing FSM between the CPU load/store port, the 4-way L1 data cache and main memory.
//  Accepts one CPU request at a time and probes the cache with it.
//  On a read miss: fetches the word from memory, then fills the cache.
//  Writes are write-through / no-write-allocate. Owns every cache and memory control strobe.
// PARAMETERS
//  ADDR_WIDTH  32  CPU/memory address width
//  DATA_WIDTH  32  data word width
//  CNT_WIDTH   32  perf counter width (CACHE_PERF_CNT_EN only)
// PORTS
//  clk                 in   1           clock, rising edge
//  rst                 in   1           asynchronous, active-high reset
//  cpu_req_i           in   1           request valid
//  cpu_ready_o         out  1           controller can accept (IDLE only)
//  cpu_wr_en_i         in   1           1=store, 0=load
//  cpu_addr_i          in   ADDR_WIDTH  byte address
//  cpu_wr_data_i       in   DATA_WIDTH  store data, low lanes
//  cpu_byte_en_i       in   4           0001=byte, 0011=half, 1111=word
//  cpu_rsp_valid_o     out  1           one-cycle response strobe
//  cpu_rd_data_o       out  DATA_WIDTH  load data, zero-extended
//  cpu_err_o           out  1           illegal byte_en, valid with rsp strobe
//  cache_lookup_o      out  1           probe cache with cache_addr_o
//  cache_fill_o        out  1           write cache_fill_data_o into the LRU way
//  cache_wr_en_o       out  1           store-on-hit strobe to cache
//  cache_addr_o        out  ADDR_WIDTH  registered request address
//  cache_wr_data_o     out  DATA_WIDTH  registered store data
//  cache_byte_en_o     out  4           registered byte enable
//  cache_fill_data_o   out  DATA_WIDTH  word returned by memory
//  cache_hit_i         in   1           hit, valid while cache_lookup_o=1
//  cache_rd_data_i     in   DATA_WIDTH  hit data (already lane-extracted)
//  mem_req_o           out  1           memory request, held until ack
//  mem_ack_i           in   1           memory completes this cycle
//  mem_wr_en_o         out  1           memory write
//  mem_addr_o          out  ADDR_WIDTH  {addr_q[31:2],2'b00}
//  mem_wr_data_o       out  DATA_WIDTH  store data
//  mem_byte_en_o       out  4           byte_en_q on writes, 1111 on reads
//  mem_rd_data_i       in   DATA_WIDTH  read word, valid with ack
// BEHAVIOUR
//  - Reset (async): state=IDLE; all request registers, rsp data and counters = 0.
//    All outputs = 0 except cpu_ready_o=1.
//  - IDLE: cpu_ready_o=1. When cpu_req_i is high, latch addr/wr/data/be -> LOOKUP.
//    If be is illegal -> RESP with err=1; no cache or memory activity.
//  - LOOKUP (1 cycle): cache_lookup_o=1, cache_wr_en_o=wr_q.
//    * Read hit: capture cache_rd_data_i -> RESP.
//    * Read miss -> MEM_RD.
//    * Write (hit or miss) -> MEM_WR. On a hit the cache updates at this edge.
//  - MEM_RD: mem_req_o=1, mem_wr_en_o=0; address and be stable.
//    On mem_ack_i: capture mem_rd_data_i into fill_q -> FILL.
//  - FILL (1 cycle): cache_fill_o=1 with cache_fill_data_o=fill_q.
//    rsp data = fill_q extracted by be_q (0001->{24'b0,[7:0]}, 0011->{16'b0,[15:0]}, 1111->word) -> RESP.
//  - MEM_WR: mem_req_o=1, mem_wr_en_o=1 until mem_ack_i -> RESP.
//  - RESP (1 cycle): cpu_rsp_valid_o=1; cpu_rd_data_o=rsp data (0 for stores) -> IDLE.
//  - Latency from accept edge N:
//    * read hit: rsp at N+2
//    * read miss: ack at cycle M -> rsp at M+2
//    * write: ack at M -> rsp at M+1
//  - Ack arriving in the first mem_req_o cycle is legal. mem_ack_i outside MEM_RD/MEM_WR is ignored.
//  - cache_lookup_o and cache_fill_o are never high together. At most one request is outstanding.
//  - cpu_req_i outside IDLE is ignored (not queued).
//  - rst mid-transaction: abort immediately, mem_req_o drops the same cycle, no response issued.
// CONFIGURATION
//  - CACHE_PERF_CNT_EN defined: adds outputs hit_cnt_o and miss_cnt_o (CNT_WIDTH each).
//    Each increments by 1 in LOOKUP on hit or miss, reads and writes both counted.
//    Illegal-be requests are not counted. Counters saturate at all-ones and are cleared by rst.
//  - CACHE_PERF_CNT_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  - Read miss: load 0x100, be=1111, cache_hit_i=0, mem ack after 3 cycles with 0xCAFEF00D
//    -> FILL with fill data 0xCAFEF00D; rsp data 0xCAFEF00D two cycles after ack.
//  - Read hit: load 0x100, hit with cache_rd_data_i=0x12345678 -> rsp at N+2 with 0x12345678; mem_req_o never high.
//  - Store half: addr 0x204, data 0xAAAABEEF, be=0011, hit=1
//    -> cache_wr_en_o in LOOKUP; mem write to 0x204 with be 0011; rsp 1 cycle after ack, data 0.
//  - Illegal be: load with be=0101 -> rsp at N+2 with err=1, data 0; no lookup, fill or mem_req.
//  - Reset mid-operation: assert rst during MEM_RD
//    -> mem_req_o=0 the same cycle, cpu_ready_o=1, no rsp strobe; next read proceeds normally.
//  - CACHE_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt_o=3, miss_cnt_o=2;
//    with CNT_WIDTH=2, 5 hits -> hit_cnt_o stays 3.

Source files
------------

// File: rtl/l1_cache_ctrl.sv
// Request sequencer between the CPU port, a 4-way L1 data cache and main memory (write-through, no-write-allocate).
// Optional perf counters hit_cnt_o/miss_cnt_o are enabled by defining CACHE_PERF_CNT_EN.
module l1_cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
`ifdef CACHE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  output logic                  cpu_ready_o,
  input  logic                  cpu_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
  input  logic [3:0]            cpu_byte_en_i,
  output logic                  cpu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
  output logic                  cpu_err_o,
  output logic                  cache_lookup_o,
  output logic                  cache_fill_o,
  output logic                  cache_wr_en_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wr_data_o,
  output logic [3:0]            cache_byte_en_o,
  output logic [DATA_WIDTH-1:0] cache_fill_data_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rd_data_i,
  output logic                  mem_req_o,
  input  logic                  mem_ack_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  be_ok;

  logic ready_q, ready_d, lookup_q, lookup_d, cwr_q, cwr_d, cfill_q, cfill_d;
  logic mreq_q, mreq_d, mwr_q, mwr_d, rsp_q, rsp_d, err_o_q, err_o_d;

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
`endif

  // Next-state and request-register update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    mem_be_d   = mem_be_q;
    err_d      = err_q;
    fill_d     = fill_q;
    rsp_data_d = rsp_data_q;
    be_ok      = (cpu_byte_en_i == 4'b0001) || (cpu_byte_en_i == 4'b0011) ||
                 (cpu_byte_en_i == 4'b1111);
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          addr_d     = cpu_addr_i;
          wr_d       = cpu_wr_en_i;
          wdata_d    = cpu_wr_data_i;
          be_d       = cpu_byte_en_i;
          mem_be_d   = cpu_wr_en_i ? cpu_byte_en_i : 4'b1111;
          err_d      = !be_ok;
          rsp_data_d = '0;
          state_d    = S_LOOKUP;
        end
      end
      // An illegal request passes through LOOKUP silently to keep response timing uniform
      S_LOOKUP: begin
        if (err_q) begin
          state_d = S_RESP;
        end else if (wr_q) begin
          state_d = S_MEM_WR;
        end else if (cache_hit_i) begin
          rsp_data_d = cache_rd_data_i;
          state_d    = S_RESP;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ack_i) begin
          fill_d  = mem_rd_data_i;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        case (be_q)
          4'b0001: rsp_data_d = DATA_WIDTH'(fill_q[7:0]);
          4'b0011: rsp_data_d = DATA_WIDTH'(fill_q[15:0]);
          default: rsp_data_d = fill_q;
        endcase
        state_d = S_RESP;
      end
      S_MEM_WR: begin
        if (mem_ack_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave the flops aligned with the state
    ready_d  = (state_d == S_IDLE);
    lookup_d = (state_d == S_LOOKUP) && !err_d;
    cwr_d    = lookup_d && wr_d;
    cfill_d  = (state_d == S_FILL);
    mreq_d   = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    mwr_d    = (state_d == S_MEM_WR);
    rsp_d    = (state_d == S_RESP);
    err_o_d  = rsp_d && err_d;
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating hit/miss counters, sampled on every legal lookup
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_LOOKUP) && !err_q) begin
      if (cache_hit_i) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_be_q   <= '0;
      err_q      <= 1'b0;
      fill_q     <= '0;
      rsp_data_q <= '0;
      ready_q    <= 1'b1;
      lookup_q   <= 1'b0;
      cwr_q      <= 1'b0;
      cfill_q    <= 1'b0;
      mreq_q     <= 1'b0;
      mwr_q      <= 1'b0;
      rsp_q      <= 1'b0;
      err_o_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      mem_be_q   <= mem_be_d;
      err_q      <= err_d;
      fill_q     <= fill_d;
      rsp_data_q <= rsp_data_d;
      ready_q    <= ready_d;
      lookup_q   <= lookup_d;
      cwr_q      <= cwr_d;
      cfill_q    <= cfill_d;
      mreq_q     <= mreq_d;
      mwr_q      <= mwr_d;
      rsp_q      <= rsp_d;
      err_o_q    <= err_o_d;
    end
  end

  assign cpu_ready_o       = ready_q;
  assign cpu_rsp_valid_o   = rsp_q;
  assign cpu_rd_data_o     = rsp_data_q;
  assign cpu_err_o         = err_o_q;
  assign cache_lookup_o    = lookup_q;
  assign cache_fill_o      = cfill_q;
  assign cache_wr_en_o     = cwr_q;
  assign cache_addr_o      = addr_q;
  assign cache_wr_data_o   = wdata_q;
  assign cache_byte_en_o   = be_q;
  assign cache_fill_data_o = fill_q;
  assign mem_req_o         = mreq_q;
  assign mem_wr_en_o       = mwr_q;
  assign mem_addr_o        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wr_data_o     = wdata_q;
  assign mem_byte_en_o     = mem_be_q;

endmodule
